// File: rtl/ex_data_fifo_rd_packer.sv
// rtl/ex_data_fifo_rd_packer.sv - drains N bytes from a 1-cycle-latency FIFO and packs them into 32-bit words
// Little-endian packing with keep/last; one byte per clock while the sink keeps up.
module ex_data_fifo_rd_packer #(
  parameter int LEN_WIDTH   = 12,
  parameter int FIFO_RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] frame_len,
  output logic                 busy,
  output logic                 done,
  output logic                 fifo_rd_en,
  input  logic [7:0]           fifo_rd_data,
  input  logic                 fifo_rd_empty,
  output logic [31:0]          m_data,
  output logic [3:0]           m_keep,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  if (FIFO_RD_LAT != 1) begin : g_bad_lat
    $error("ex_data_fifo_rd_packer: only FIFO_RD_LAT == 1 is supported");
  end

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] req_cnt_q, req_cnt_d;
  logic [1:0]           asm_cnt_q, asm_cnt_d;
  logic [31:0]          asm_data_q, asm_data_d;
  logic                 pend_q, pend_d;
  logic                 pend_final_q, pend_final_d;
  logic [31:0]          m_data_q, m_data_d;
  logic [3:0]           m_keep_q, m_keep_d;
  logic                 m_last_q, m_last_d;
  logic                 m_valid_q, m_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 issue_final;
  logic                 issue_completes;
  logic                 arrive_complete;
  logic                 slot_ok;
  logic                 rd_en;
  logic [4:0]           lane_bit;
  logic [31:0]          word;

  always_comb begin
    issue_final     = (req_cnt_q == len_q - LEN_WIDTH'(1));
    issue_completes = (req_cnt_q[1:0] == 2'd3) || issue_final;
    arrive_complete = pend_q && ((asm_cnt_q == 2'd3) || pend_final_q);
    // A completing byte landing this cycle refills the slot, so the next
    // completing read must wait one cycle or it could overrun an unaccepted word.
    slot_ok         = !issue_completes || ((!m_valid_q || m_ready) && !arrive_complete);
    rd_en           = (state_q == READ) && !fifo_rd_empty && (req_cnt_q < len_q) && slot_ok;
    lane_bit        = {asm_cnt_q, 3'b000};
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    req_cnt_d    = req_cnt_q;
    asm_cnt_d    = asm_cnt_q;
    asm_data_d   = asm_data_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_last_d     = m_last_q;
    m_valid_d    = m_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pend_d       = rd_en;
    pend_final_d = rd_en && issue_final;
    word         = asm_data_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (pend_q) begin
      word[lane_bit +: 8] = fifo_rd_data;
      if (arrive_complete) begin
        m_data_d   = word;
        m_last_d   = pend_final_q;
        m_valid_d  = 1'b1;
        asm_cnt_d  = 2'd0;
        asm_data_d = 32'h0;
        case (asm_cnt_q)
          2'd0:    m_keep_d = 4'b0001;
          2'd1:    m_keep_d = 4'b0011;
          2'd2:    m_keep_d = 4'b0111;
          default: m_keep_d = 4'b1111;
        endcase
      end else begin
        asm_data_d = word;
        asm_cnt_d  = asm_cnt_q + 2'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            len_d     = frame_len;
            req_cnt_d = '0;
            busy_d    = 1'b1;
            state_d   = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (rd_en) begin
          req_cnt_d = req_cnt_q + LEN_WIDTH'(1);
          if (issue_final) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (m_valid_q && m_ready && m_last_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      req_cnt_q    <= '0;
      asm_cnt_q    <= 2'd0;
      asm_data_q   <= 32'h0;
      pend_q       <= 1'b0;
      pend_final_q <= 1'b0;
      m_data_q     <= 32'h0;
      m_keep_q     <= 4'h0;
      m_last_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      req_cnt_q    <= req_cnt_d;
      asm_cnt_q    <= asm_cnt_d;
      asm_data_q   <= asm_data_d;
      pend_q       <= pend_d;
      pend_final_q <= pend_final_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_last_q     <= m_last_d;
      m_valid_q    <= m_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign busy       = busy_q;
  assign done       = done_q;
  assign m_data     = m_data_q;
  assign m_keep     = m_keep_q;
  assign m_last     = m_last_q;
  assign m_valid    = m_valid_q;

endmodule

// File: tb/tb_ex_data_fifo_rd_packer.sv
// tb/tb_ex_data_fifo_rd_packer.sv - scoreboard bench for ex_data_fifo_rd_packer
module tb_ex_data_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] frame_len = 12'd0;
  logic        busy, done, fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_empty;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last, m_valid;
  logic        m_ready = 1'b1;

  ex_data_fifo_rd_packer #(.LEN_WIDTH(12), .FIFO_RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // FIFO model: byte i holds 0xFF - i
  logic [7:0] mem [0:63];
  int         rd_ptr = 0;
  logic       flush = 1'b0;
  logic       empty_force = 1'b0;
  assign fifo_rd_empty = empty_force || (rd_ptr >= 64);

  always @(posedge clk) begin
    if (flush) rd_ptr <= 0;
    else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   rd_cycles[$];
  int   done_cycles[$];
  int   last_acc_cyc = -1;
  int   checks = 0;
  int   failures = 0;
  exp_t got_w;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rd_en) begin
        rd_cycles.push_back(cyc);
        checks++;
        if (fifo_rd_empty) begin
          failures++;
          $display("FAIL read_when_empty: got fifo_rd_en=1 want 0 at cycle %0d", cyc);
        end
      end
      if (m_valid) begin
        got_w = {m_data, m_keep, m_last};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got %h want none", got_w);
        end else begin
          if (got_w !== exp_q[0]) begin
            failures++;
            $display("FAIL word(data,keep,last): got %h want %h", got_w, exp_q[0]);
          end
          if (m_ready) begin
            if (m_last) last_acc_cyc = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) done_cycles.push_back(cyc);
    end
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int len, output int s);
    start = 1'b1;
    frame_len = 12'(len);
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic push_exp(logic [31:0] d, logic [3:0] k, logic l);
    exp_t e;
    e.d = d; e.k = k; e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(int d0, string name);
    for (int i = 0; i < 400 && done_cycles.size() <= d0; i++) tick();
    chk(name, done_cycles.size() > d0, 1);
  endtask

  task automatic wait_reads(int target, string name);
    for (int i = 0; i < 100 && rd_cycles.size() < target; i++) tick();
    chk(name, rd_cycles.size() >= target, 1);
  endtask

  task automatic check_idle_outputs(string name);
    chk({name, "_outputs"}, {busy, done, fifo_rd_en, m_valid, m_last, m_keep, m_data}, 0);
  endtask

  int s, s2, n0, d0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(8'hFF - i);
    #2;
    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // len=8, sink always ready
    n0 = rd_cycles.size(); d0 = done_cycles.size();
    push_exp(32'hFCFDFEFF, 4'hF, 1'b0);
    push_exp(32'hF8F9FAFB, 4'hF, 1'b1);
    do_start(8, s);
    wait_done(d0, "t1_done_seen");
    chk("t1_reads", rd_cycles.size() - n0, 8);
    if (rd_cycles.size() - n0 >= 8) begin
      chk("t1_first_read_lat", rd_cycles[n0], s + 1);
      chk("t1_read_span", rd_cycles[n0+7] - rd_cycles[n0], 7);
    end
    if (done_cycles.size() > d0) chk("t1_done_after_last", done_cycles[d0], last_acc_cyc + 1);
    chk("t1_queue_drained", exp_q.size(), 0);
    chk("t1_busy_low", busy, 0);

    // len=5, partial final word
    do_flush();
    n0 = rd_cycles.size(); d0 = done_cycles.size();
    push_exp(32'hFCFDFEFF, 4'hF, 1'b0);
    push_exp(32'h000000FB, 4'h1, 1'b1);
    do_start(5, s);
    wait_done(d0, "t2_done_seen");
    tick();
    chk("t2_reads", rd_cycles.size() - n0, 5);
    chk("t2_queue_drained", exp_q.size(), 0);

    // len=8 with sink back-pressure for 10 cycles
    do_flush();
    n0 = rd_cycles.size(); d0 = done_cycles.size();
    push_exp(32'hFCFDFEFF, 4'hF, 1'b0);
    push_exp(32'hF8F9FAFB, 4'hF, 1'b1);
    do_start(8, s);
    for (int i = 0; i < 50 && !m_valid; i++) tick();
    chk("t3_first_valid_seen", m_valid, 1);
    m_ready = 1'b0;
    repeat (10) tick();
    chk("t3_reads_during_stall", rd_cycles.size() - n0, 7);
    m_ready = 1'b1;
    wait_done(d0, "t3_done_seen");
    chk("t3_reads", rd_cycles.size() - n0, 8);
    if (rd_cycles.size() - n0 >= 8) begin
      chk("t3_first7_span", rd_cycles[n0+6] - rd_cycles[n0], 6);
      chk("t3_stall_gap", rd_cycles[n0+7] - rd_cycles[n0+6] > 5, 1);
    end
    chk("t3_queue_drained", exp_q.size(), 0);

    // empty pulse of 3 cycles after 3 reads
    do_flush();
    n0 = rd_cycles.size(); d0 = done_cycles.size();
    push_exp(32'hFCFDFEFF, 4'hF, 1'b0);
    push_exp(32'hF8F9FAFB, 4'hF, 1'b1);
    do_start(8, s);
    wait_reads(n0 + 3, "t4_three_reads");
    empty_force = 1'b1;
    repeat (3) tick();
    empty_force = 1'b0;
    wait_done(d0, "t4_done_seen");
    chk("t4_reads", rd_cycles.size() - n0, 8);
    if (rd_cycles.size() - n0 >= 8) begin
      chk("t4_gap", rd_cycles[n0+3] - rd_cycles[n0+2], 4);
      chk("t4_span", rd_cycles[n0+7] - rd_cycles[n0], 10);
    end
    chk("t4_queue_drained", exp_q.size(), 0);

    // len=0, then start while busy
    do_flush();
    n0 = rd_cycles.size(); d0 = done_cycles.size();
    do_start(0, s);
    chk("t5_busy_zero_len", busy, 0);
    tick();
    tick();
    chk("t5_done_count", done_cycles.size() - d0, 1);
    if (done_cycles.size() > d0) chk("t5_done_cycle", done_cycles[d0], s + 1);
    chk("t5_no_reads", rd_cycles.size() - n0, 0);
    chk("t5_no_valid", m_valid, 0);
    d0 = done_cycles.size();
    push_exp(32'hFCFDFEFF, 4'hF, 1'b1);
    do_start(4, s);
    chk("t5_busy", busy, 1);
    do_start(8, s2);
    wait_done(d0, "t5_done_seen");
    repeat (10) tick();
    chk("t5_reads_busy_start", rd_cycles.size() - n0, 4);
    chk("t5_single_done", done_cycles.size() - d0, 1);
    chk("t5_queue_drained", exp_q.size(), 0);

    // reset mid-frame after 3 reads
    do_flush();
    n0 = rd_cycles.size();
    do_start(8, s);
    wait_reads(n0 + 3, "t6_three_reads");
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_reset");
    chk("t6_fifo_ptr", rd_ptr, 3);
    tick();
    rst_n = 1'b1;
    tick();
    n0 = rd_cycles.size(); d0 = done_cycles.size();
    push_exp(32'hF9FAFBFC, 4'hF, 1'b1);
    do_start(4, s);
    wait_done(d0, "t6_done_seen");
    chk("t6_reads", rd_cycles.size() - n0, 4);
    chk("t6_queue_drained", exp_q.size(), 0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
